// File: rtl/memc_req_arbiter.sv
// Arbitrates one MemC command port between NUM_REQ requesters with a registered command output.
// Define MEMC_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.

package memc_arb_pkg;
    typedef enum logic [2:0] {
        MEMC_NONE         = 3'd0,
        MEMC_PAGE_WALK    = 3'd1,
        MEMC_READ_LINE    = 3'd2,
        MEMC_WRITE_LINE   = 3'd3,
        MEMC_READ_SINGLE  = 3'd4,
        MEMC_WRITE_SINGLE = 3'd5
    } MemC_Cmd;

    typedef struct packed {
        MemC_Cmd     cmd;
        logic [2:0]  rqID;
        logic [11:0] sramAddr;
        logic [29:0] extAddr;
    } CTRL_MemC;

    typedef struct packed {
        logic       busy;
        logic [2:0] rqID;
    } STAT_MemC;
endpackage

module memc_req_arbiter
    import memc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  CTRL_MemC           IN_req [NUM_REQ-1:0],
    output logic [NUM_REQ-1:0] OUT_accepted,
    output logic [IDX_W-1:0]   OUT_grantIdx,
    output CTRL_MemC           OUT_memc,
    input  STAT_MemC           IN_memc,
    output logic               OUT_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    CTRL_MemC           memc_q, memc_d;
    logic [NUM_REQ-1:0] acc_q, acc_d;
    logic [NUM_REQ-1:0] mask_q;
    logic [NUM_REQ-1:0] cand;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;

    // A requester pulsed last cycle may still hold its command; keep it out for one cycle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            cand[i] = (IN_req[i].cmd != MEMC_NONE) && !mask_q[i];
    end

`ifdef MEMC_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] rr_idx;

    // Walk downward so the candidate closest to the pointer is assigned last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        rr_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (cand[rr_idx]) begin
                win_vld = 1'b1;
                win_idx = rr_idx;
            end
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        memc_d  = memc_q;
        acc_d   = '0;
`ifdef MEMC_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (!IN_memc.busy && win_vld) begin
                    grant_d = win_idx;
                    memc_d  = IN_req[win_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Acceptance is checked first so it wins over a same-cycle cancel.
                if (IN_memc.busy && IN_memc.rqID == memc_q.rqID) begin
                    memc_d.cmd     = MEMC_NONE;
                    acc_d[grant_q] = 1'b1;
                    state_d        = BUSY;
`ifdef MEMC_ARB_RR_EN
                    ptr_d          = IDX_W'((int'(grant_q) + 1) % NUM_REQ);
`endif
                end else if (IN_req[grant_q].cmd == MEMC_NONE) begin
                    memc_d.cmd = MEMC_NONE;
                    grant_d    = '0;
                    state_d    = IDLE;
                end
            end
            BUSY: begin
                if (!IN_memc.busy) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d    = '0;
                memc_d.cmd = MEMC_NONE;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            memc_q  <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
`ifdef MEMC_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            memc_q  <= memc_d;
            acc_q   <= acc_d;
            mask_q  <= acc_q;
`ifdef MEMC_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign OUT_accepted = acc_q;
    assign OUT_grantIdx = grant_q;
    assign OUT_memc     = memc_q;
    assign OUT_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_memc_req_arbiter.sv
// Bench for memc_req_arbiter: directed scenarios plus random requesters and a MemC responder,
// all checked every cycle against a transaction-level reference model.
module tb_memc_req_arbiter;
    import memc_arb_pkg::*;

    localparam int N = 4;
`ifdef MEMC_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    CTRL_MemC       req [N-1:0];
    STAT_MemC       stat;
    logic [N-1:0]   acc;
    logic [1:0]     gidx;
    CTRL_MemC       memc_o;
    logic           busy_o;

    always #5 clk = ~clk;

    memc_req_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .IN_req(req), .OUT_accepted(acc),
        .OUT_grantIdx(gidx), .OUT_memc(memc_o), .IN_memc(stat), .OUT_busy(busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether the command is on offer or in flight.
    int           m_phase;   // 0 free, 1 offered to MemC, 2 MemC working on it
    int           m_owner;
    int           m_ptr;
    CTRL_MemC     m_lat;
    logic [N-1:0] m_acc, m_mask;
    logic [2:0]   rqid_tab [N];

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = RR ? (m_ptr + k) % N : k;
            if (req[i].cmd != MEMC_NONE && !m_mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] nacc;
        int w;
        if (rst) begin
            m_phase = 0; m_owner = -1; m_ptr = 0; m_acc = '0; m_mask = '0;
        end else begin
            nacc = '0;
            case (m_phase)
                0: if (!stat.busy) begin
                    w = pick();
                    if (w >= 0) begin m_lat = req[w]; m_owner = w; m_phase = 1; end
                end
                1: if (stat.busy && stat.rqID == m_lat.rqID) begin
                    nacc = N'(1) << m_owner;
                    m_ptr = (m_owner + 1) % N;
                    m_phase = 2;
                end else if (req[m_owner].cmd == MEMC_NONE) begin
                    m_phase = 0; m_owner = -1;
                end
                default: if (!stat.busy) begin m_phase = 0; m_owner = -1; end
            endcase
            m_mask = m_acc;
            m_acc  = nacc;
        end
    endtask

    task automatic check_outs();
        chk("busy", busy_o, m_phase != 0);
        chk("accepted", acc, m_acc);
        chk("grantIdx", gidx, (m_phase == 0) ? 0 : m_owner);
        chk("memc_cmd", memc_o.cmd, 64'((m_phase == 1) ? m_lat.cmd : MEMC_NONE));
        if (m_phase == 1) begin
            chk("memc_rqid", memc_o.rqID, m_lat.rqID);
            chk("memc_ext", memc_o.extAddr, m_lat.extAddr);
            chk("memc_sram", memc_o.sramAddr, m_lat.sramAddr);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic set_req(input int i, input MemC_Cmd c);
        req[i].cmd      = c;
        req[i].rqID     = rqid_tab[i];
        req[i].sramAddr = 12'($urandom);
        req[i].extAddr  = 30'($urandom);
    endtask

    logic [N-1:0] drop_pend;
    int mc_cnt, mc_dly;

    task automatic do_reset();
        for (int i = 0; i < N; i++) req[i] = '0;
        stat = '0; drop_pend = '0; mc_cnt = 0; mc_dly = 0;
        rst = 1'b1; step(); step();
        rst = 1'b0;
    endtask

    // Requesters obey the contract: hold through the pulse cycle, drop the cycle after.
    task automatic drive_agents();
        for (int i = 0; i < N; i++) begin
            if (drop_pend[i]) begin
                req[i].cmd = MEMC_NONE; drop_pend[i] = 1'b0;
            end else if (acc[i]) begin
                drop_pend[i] = 1'b1;
            end else if (req[i].cmd != MEMC_NONE) begin
                if ($urandom_range(0, 15) == 0) req[i].cmd = MEMC_NONE;
                else if ($urandom_range(0, 3) == 0) req[i].extAddr = 30'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                set_req(i, MemC_Cmd'($urandom_range(1, 5)));
            end
        end
    endtask

    task automatic drive_memc(input bit fixed);
        if (mc_cnt > 0) begin
            mc_cnt--; stat.busy = 1'b1;
        end else if (memc_o.cmd != MEMC_NONE) begin
            if (mc_dly == 0) begin
                stat.busy = 1'b1; stat.rqID = memc_o.rqID;
                mc_cnt = fixed ? 2 : int'($urandom_range(0, 3));
                mc_dly = fixed ? 0 : int'($urandom_range(0, 3));
            end else begin
                mc_dly--;
                stat.busy = ($urandom_range(0, 3) == 0);
                stat.rqID = memc_o.rqID ^ 3'd1;
            end
        end else if (!fixed && $urandom_range(0, 15) == 0) begin
            stat.busy = 1'b1; stat.rqID = 3'($urandom);
        end else begin
            stat.busy = 1'b0;
        end
    endtask

    int log_q[$];
    int exp2 [4];

    initial begin
        rqid_tab[0] = 3'd2; rqid_tab[1] = 3'd4; rqid_tab[2] = 3'd6; rqid_tab[3] = 3'd1;
        m_owner = -1; m_phase = 0; m_ptr = 0; m_acc = '0; m_mask = '0; m_lat = '0;

        // Single request
        do_reset();
        step();
        set_req(1, MEMC_PAGE_WALK);
        step();
        chk("t1_cmd", memc_o.cmd, MEMC_PAGE_WALK);
        chk("t1_rqid", memc_o.rqID, 3'd4);
        step();
        stat.busy = 1'b1; stat.rqID = 3'd4;
        step();
        chk("t1_acc", acc, 4'b0010);
        chk("t1_none", memc_o.cmd, MEMC_NONE);
        stat.busy = 1'b0;
        step();
        chk("t1_acc_once", acc, 4'b0000);
        req[1].cmd = MEMC_NONE;
        step(); step();

        // Contention between req0 and req2
        do_reset();
        set_req(0, MEMC_READ_LINE); set_req(2, MEMC_READ_LINE);
        log_q.delete();
        for (int c = 0; c < 200 && log_q.size() < 4; c++) begin
            for (int i = 0; i < N; i += 2) begin
                if (drop_pend[i]) begin req[i].cmd = MEMC_NONE; drop_pend[i] = 1'b0; end
                else if (acc[i]) drop_pend[i] = 1'b1;
                else req[i].cmd = MEMC_READ_LINE;
            end
            drive_memc(1'b1);
            step();
            if (acc != '0) log_q.push_back(int'(gidx));
        end
        if (RR) exp2 = '{0, 2, 0, 2};
        else    exp2 = '{0, 0, 0, 0};
        chk("t2_count", log_q.size(), 4);
        for (int k = 0; k < 4 && k < log_q.size(); k++) chk("t2_grant", log_q[k], exp2[k]);

        // Cancel in ISSUE, another requester picks up right after
        do_reset();
        set_req(3, MEMC_READ_LINE);
        step();
        chk("t3_gidx3", gidx, 2'd3);
        req[3].cmd = MEMC_NONE;
        set_req(1, MEMC_READ_LINE);
        step();
        chk("t3_idle", busy_o, 1'b0);
        chk("t3_nopulse", acc, 4'b0000);
        step();
        chk("t3_gidx1", gidx, 2'd1);
        chk("t3_rqid", memc_o.rqID, 3'd4);
        req[1].cmd = MEMC_NONE;
        step();

        // Accept and cancel in the same cycle
        do_reset();
        set_req(0, MEMC_WRITE_LINE);
        step();
        stat.busy = 1'b1; stat.rqID = 3'd2;
        req[0].cmd = MEMC_NONE;
        step();
        chk("t4_acc", acc, 4'b0001);
        chk("t4_busy", busy_o, 1'b1);
        stat.busy = 1'b0;
        step(); step();

        // One-cycle MemC op with the requester still holding after its pulse
        do_reset();
        set_req(2, MEMC_READ_SINGLE);
        step();
        stat.busy = 1'b1; stat.rqID = 3'd6;
        step();
        chk("t5_acc", acc, 4'b0100);
        stat.busy = 1'b0;
        step();
        chk("t5_idle", busy_o, 1'b0);
        step();
        chk("t5_masked", memc_o.cmd, MEMC_NONE);
        req[2].cmd = MEMC_NONE;
        step();

        // Reset while BUSY
        do_reset();
        set_req(1, MEMC_READ_LINE);
        step();
        stat.busy = 1'b1; stat.rqID = 3'd4;
        step();
        chk("t6_busy", busy_o, 1'b1);
        rst = 1'b1;
        step();
        chk("t6_rst_busy", busy_o, 1'b0);
        chk("t6_rst_cmd", memc_o.cmd, MEMC_NONE);
        chk("t6_rst_acc", acc, 4'b0000);
        rst = 1'b0; stat.busy = 1'b0; req[1].cmd = MEMC_NONE;
        step();
        set_req(1, MEMC_WRITE_SINGLE);
        step();
        chk("t6_reissue", memc_o.cmd, MEMC_WRITE_SINGLE);
        chk("t6_rqid", memc_o.rqID, 3'd4);

        // Random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive_agents();
            drive_memc(1'b0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memc_req_arbiter.md
# memc_req_arbiter

Arbitrates one memory-controller command port between `NUM_REQ` requesters: ifetch page walk, ICache miss, DCache miss and load/store page walk. Each requester presents a `CTRL_MemC` command level-held until acceptance. The arbiter latches the winner, drives it to MemC through a registered port, detects acceptance via `STAT_MemC`, pulses a per-requester accept, and blocks new grants until MemC returns idle. It replaces the point-to-point `OUT_memc`/`OUT_memc2` wiring between fetch/cache blocks and MemC.

## Interface
- `NUM_REQ`, 4, number of requesters; index 0 is the highest fixed priority.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `IN_req[NUM_REQ-1:0]` in `$bits(CTRL_MemC)` each: per-requester command. Valid when `cmd != MEMC_NONE`; `rqID` must be unique per requester.
- `OUT_accepted[NUM_REQ-1:0]` out 1 each: one-cycle pulse when that requester's command was taken by MemC.
- `OUT_grantIdx` out `$clog2(NUM_REQ)`: index of the latched requester; 0 when idle.
- `OUT_memc` out `$bits(CTRL_MemC)`: registered command to MemC.
- `IN_memc` in `$bits(STAT_MemC)`: MemC status. Uses `busy` and `rqID`.
- `OUT_busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, BUSY.
- **IDLE**
  - Pick the winner among valid, unmasked requests.
  - Latch its index and full command. Register the command onto `OUT_memc`. Go to ISSUE.
  - Requests are ignored while `IN_memc.busy` is high.
- **ISSUE**
  - `OUT_memc` holds the latched command.
  - If `IN_memc.busy && IN_memc.rqID == latched.rqID`:
    - next edge sets `OUT_memc.cmd <= MEMC_NONE`;
    - pulse `OUT_accepted[g]` for one cycle;
    - go to BUSY.
  - Else if `IN_req[g].cmd == MEMC_NONE` (cancel): `OUT_memc.cmd <= MEMC_NONE`, go to IDLE, no pulse.
- **BUSY**
  - `OUT_memc.cmd` stays MEMC_NONE.
  - When `!IN_memc.busy`, go to IDLE.
- **Requester contract:** drop `cmd` to MEMC_NONE in the cycle after its accept pulse.
- **Re-grant mask:** a requester whose accept pulsed in cycle t is masked from arbitration in cycle t+1. This covers MemC operations shorter than the requester's drop latency.
- **Simultaneous accept and cancel:** accept wins.
- **Latched data:** other fields of `IN_req[g]` changing during ISSUE have no effect. Only the latched copy is driven.
- **Reset:**
  - outputs: `OUT_memc.cmd = MEMC_NONE`, `OUT_accepted = 0`, `OUT_grantIdx = 0`, `OUT_busy = 0`;
  - state IDLE, RR pointer 0, mask cleared, other `OUT_memc` fields X.
  - Reset mid-ISSUE or mid-BUSY drops the grant without any pulse.

## Timing
- Request valid in cycle t, arbiter IDLE and MemC not busy → `OUT_memc.cmd` valid at t+1.
- MemC acceptance seen in cycle a → `OUT_accepted[g]` high in a+1 only, and `OUT_memc.cmd = MEMC_NONE` in a+1.
- BUSY→IDLE on the edge after `!IN_memc.busy`. The earliest next `OUT_memc` command is two cycles after `busy` falls.
- Back-to-back throughput: one command per MemC operation.
- No combinational path from `IN_req` or `IN_memc` to any output.

## Configuration
- `MEMC_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at pointer `p`.
  - On an accepted grant to `i`, set `p <= (i+1) % NUM_REQ`.
  - A cancel does not move `p`.
- `MEMC_ARB_RR_EN` not defined: fixed priority, lowest valid index wins. There is no pointer register.

## Test plan
- **Single request:** after reset, req1 issues MEMC_PAGE_WALK with rqID=4 at t=2.
  - `OUT_memc` shows rqID=4 at t=3.
  - MemC raises `busy` with rqID=4 at t=5 → `OUT_accepted[1]` pulses at t=6 only, `OUT_memc.cmd = NONE` at t=6.
- **Contention:** req0 and req2 are both valid continuously.
  - With RR_EN, grants alternate 0, 2, 0, 2 across four MemC operations.
  - Without RR_EN, req0 is granted every time until it drops, then req2.
- **Cancel:** req3 is granted, then drops cmd in ISSUE before MemC accepts.
  - No accept pulse; IDLE next cycle; req1, valid the same cycle, is issued the following cycle.
  - The RR pointer is unchanged.
- **Accept and cancel collide:** MemC `busy` with matching rqID in the same cycle req0 drops cmd → accept pulse still occurs, state goes to BUSY.
- **Short op and mask:** MemC busy for 1 cycle, and req2 still holds cmd the cycle after its pulse → req2 is not re-granted that cycle; `OUT_memc.cmd` stays NONE.
- **Reset mid-BUSY:** `rst` asserted in BUSY → next cycle `OUT_busy = 0`, `OUT_memc.cmd = NONE`, no pulses; a new request issues normally after reset deasserts.
